// File: rtl/bomb_placer_if.sv
// -----------------------------------------------------------------------------
// bomb_placer_if
//   Per-player drop-bomb handshake between the player-input side (master)
//   and bomb_placer (slave).
//
//   Handshake (four-phase, level req/ack, sampled on bombClk ticks):
//     master raises reqX and holds it until it sees ackX=1; while ackX=1 the
//     okX bit is valid (1 = bomb placed, 0 = rejected) and frozen; master then
//     drops reqX and the slave drops ackX on the next tick.  A new request is
//     only honoured after ackX has been seen low again.
//
//   Signals:
//     reqA/reqB                     drop request (master -> slave)
//     o_ackA/o_ackB                 acknowledge  (slave -> master)
//     o_okA/o_okB                   placement result, valid while ack=1
//     o_bombsLeftA/o_bombsLeftB     free live-bomb slots per player
//     stateA/stateB                 per-player FSM state for observation
// -----------------------------------------------------------------------------
interface bomb_placer_if;
   logic       reqA;
   logic       reqB;
   logic       o_ackA;
   logic       o_ackB;
   logic       o_okA;
   logic       o_okB;
   logic [1:0] o_bombsLeftA;
   logic [1:0] o_bombsLeftB;
   logic [1:0] stateA;
   logic [1:0] stateB;

   modport master (
      output reqA, reqB,
      input  o_ackA, o_ackB, o_okA, o_okB, o_bombsLeftA, o_bombsLeftB,
      input  stateA, stateB
   );

   modport slave (
      input  reqA, reqB,
      output o_ackA, o_ackB, o_okA, o_okB, o_bombsLeftA, o_bombsLeftB,
      output stateA, stateB
   );
endinterface

// File: rtl/bomb_placer.sv
// -----------------------------------------------------------------------------
// bomb_placer
//   Write side of the bomb map. Turns player drop-bomb requests into new
//   state-1 bombs overlaid on the map coming back from the bomb-advance block.
//   Per player: bomb budget (MAX_BOMBS live bombs), post-placement cooldown
//   (COOLDOWN ticks) and a four-phase req/ack handshake.
//
//   Ports:
//     bombClk        game tick
//     rst            asynchronous, active-high reset
//     i_advMap       advanced map, cell k = bits [2k+1:2k], k = 10*x+y
//     playerAx/Ay/Bx/By  player coordinates
//     healthA/B      player health (0 = dead)
//     game_state     0 = running, nonzero = game over
//     o_curBombMap   i_advMap with pending placements overlaid, border = 0
//     hs             handshake/status interface (slave side)
// -----------------------------------------------------------------------------
module bomb_placer #(
   parameter int MAX_BOMBS = 2,
   parameter int COOLDOWN  = 1
) (
   input  logic         bombClk,
   input  logic         rst,
   input  logic [199:0] i_advMap,
   input  logic [3:0]   playerAx,
   input  logic [3:0]   playerAy,
   input  logic [3:0]   playerBx,
   input  logic [3:0]   playerBy,
   input  logic [1:0]   healthA,
   input  logic [1:0]   healthB,
   input  logic [1:0]   game_state,
   output logic [199:0] o_curBombMap,
   bomb_placer_if.slave hs
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_ACK  = 2'd1;
   localparam logic [1:0] ST_COOL = 2'd2;

   // Index 0 = player A, index 1 = player B.
   logic [1:0]           state_q    [2];
   logic [1:0]           state_d    [2];
   logic                 ok_q       [2];
   logic                 ok_d       [2];
   logic [1:0]           cool_q     [2];
   logic [1:0]           cool_d     [2];
   logic                 pend_v_q   [2];
   logic                 pend_v_d   [2];
   logic [6:0]           pend_idx_q [2];
   logic [6:0]           pend_idx_d [2];
   logic [MAX_BOMBS-1:0] slot_v_q   [2];
   logic [MAX_BOMBS-1:0] slot_v_d   [2];
   logic [1:0]           slot_age_q [2][MAX_BOMBS];
   logic [1:0]           slot_age_d [2][MAX_BOMBS];

   logic       req      [2];
   logic [3:0] px       [2];
   logic [3:0] py       [2];
   logic [1:0] hp       [2];
   logic [7:0] idx      [2];
   logic       playable [2];
   logic [1:0] tgt      [2];
   logic       has_free [2];
   logic       eligible [2];
   logic       accept   [2];
   logic [1:0] used     [2];
   logic       alloc_done;

   assign req[0] = hs.reqA;
   assign req[1] = hs.reqB;
   assign px[0]  = playerAx;
   assign py[0]  = playerAy;
   assign px[1]  = playerBx;
   assign py[1]  = playerBy;
   assign hp[0]  = healthA;
   assign hp[1]  = healthB;

   // Request evaluation against the map as currently presented downstream.
   always_comb begin
      for (int p = 0; p < 2; p++) begin
         idx[p]      = 8'(px[p]) * 8'd10 + 8'(py[p]);
         playable[p] = (px[p] >= 4'd1) && (px[p] <= 4'd8) &&
                       (py[p] >= 4'd1) && (py[p] <= 4'd8);
         tgt[p]      = 2'(o_curBombMap >> {idx[p], 1'b0});
         // A slot at age 2 frees on this very tick, so it is already usable.
         has_free[p] = 1'b0;
         for (int i = 0; i < MAX_BOMBS; i++) begin
            if (!slot_v_q[p][i] || (slot_age_q[p][i] == 2'd2)) begin
               has_free[p] = 1'b1;
            end
         end
         eligible[p] = (state_q[p] == ST_IDLE) && req[p] &&
                       (game_state == 2'd0) && (hp[p] != 2'd0) &&
                       playable[p] && (tgt[p] == 2'd0) && has_free[p];
      end
   end

   // Same-cell collision: A has priority.
   assign accept[0] = eligible[0];
   assign accept[1] = eligible[1] && !(eligible[0] && (idx[0] == idx[1]));

   always_comb begin
      alloc_done = 1'b0;
      for (int p = 0; p < 2; p++) begin
         state_d[p]    = state_q[p];
         ok_d[p]       = ok_q[p];
         cool_d[p]     = cool_q[p];
         pend_v_d[p]   = accept[p];
         pend_idx_d[p] = idx[p][6:0];
         slot_v_d[p]   = slot_v_q[p];

         // Age live bombs; a slot frees on the tick its age would reach 3.
         for (int i = 0; i < MAX_BOMBS; i++) begin
            slot_age_d[p][i] = slot_age_q[p][i];
            if (slot_v_q[p][i]) begin
               if (slot_age_q[p][i] == 2'd2) begin
                  slot_v_d[p][i]   = 1'b0;
                  slot_age_d[p][i] = 2'd0;
               end else begin
                  slot_age_d[p][i] = slot_age_q[p][i] + 2'd1;
               end
            end
         end

         alloc_done = 1'b0;
         for (int i = 0; i < MAX_BOMBS; i++) begin
            if (accept[p] && !alloc_done &&
                (!slot_v_q[p][i] || (slot_age_q[p][i] == 2'd2))) begin
               slot_v_d[p][i]   = 1'b1;
               slot_age_d[p][i] = 2'd0;
               alloc_done       = 1'b1;
            end
         end

         case (state_q[p])
            ST_IDLE: begin
               if (req[p]) begin
                  state_d[p] = ST_ACK;
                  ok_d[p]    = accept[p];
               end
            end
            ST_ACK: begin
               if (!req[p]) begin
                  ok_d[p] = 1'b0;
                  if (ok_q[p] && (COOLDOWN > 0)) begin
                     state_d[p] = ST_COOL;
                     cool_d[p]  = 2'(COOLDOWN - 1);
                  end else begin
                     state_d[p] = ST_IDLE;
                  end
               end
            end
            ST_COOL: begin
               if (cool_q[p] == 2'd0) begin
                  state_d[p] = ST_IDLE;
               end else begin
                  cool_d[p] = cool_q[p] - 2'd1;
               end
            end
            default: state_d[p] = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge bombClk or posedge rst) begin
      if (rst) begin
         for (int p = 0; p < 2; p++) begin
            state_q[p]    <= ST_IDLE;
            ok_q[p]       <= 1'b0;
            cool_q[p]     <= 2'd0;
            pend_v_q[p]   <= 1'b0;
            pend_idx_q[p] <= 7'd0;
            slot_v_q[p]   <= '0;
            for (int i = 0; i < MAX_BOMBS; i++) begin
               slot_age_q[p][i] <= 2'd0;
            end
         end
      end else begin
         for (int p = 0; p < 2; p++) begin
            state_q[p]    <= state_d[p];
            ok_q[p]       <= ok_d[p];
            cool_q[p]     <= cool_d[p];
            pend_v_q[p]   <= pend_v_d[p];
            pend_idx_q[p] <= pend_idx_d[p];
            slot_v_q[p]   <= slot_v_d[p];
            for (int i = 0; i < MAX_BOMBS; i++) begin
               slot_age_q[p][i] <= slot_age_d[p][i];
            end
         end
      end
   end

   always_comb begin
      for (int p = 0; p < 2; p++) begin
         used[p] = 2'd0;
         for (int i = 0; i < MAX_BOMBS; i++) begin
            used[p] = used[p] + {1'b0, slot_v_q[p][i]};
         end
      end
   end

   assign hs.o_ackA       = (state_q[0] == ST_ACK);
   assign hs.o_ackB       = (state_q[1] == ST_ACK);
   assign hs.o_okA        = ok_q[0];
   assign hs.o_okB        = ok_q[1];
   assign hs.o_bombsLeftA = 2'(MAX_BOMBS) - used[0];
   assign hs.o_bombsLeftB = 2'(MAX_BOMBS) - used[1];
   assign hs.stateA       = state_q[0];
   assign hs.stateB       = state_q[1];

   // Map merge: border cells are always 0; a pending placement shows as 1
   // only where the advanced map is still empty.
   for (genvar k = 0; k < 100; k++) begin : g_cell
      if ((k / 10 == 0) || (k / 10 == 9) || (k % 10 == 0) || (k % 10 == 9)) begin : g_border
         logic unused_adv;
         assign unused_adv = ^i_advMap[2*k +: 2];
         assign o_curBombMap[2*k +: 2] = 2'b00;
      end else begin : g_play
         logic hit;
         assign hit = (pend_v_q[0] && (pend_idx_q[0] == 7'(k))) ||
                      (pend_v_q[1] && (pend_idx_q[1] == 7'(k)));
         assign o_curBombMap[2*k +: 2] =
            (hit && (i_advMap[2*k +: 2] == 2'b00)) ? 2'b01 : i_advMap[2*k +: 2];
      end
   end

endmodule

// File: tb/tb_bomb_placer.sv
module tb_bomb_placer;

  logic         bombClk;
  logic         rst;
  logic [3:0]   pax, pay, pbx, pby;
  logic [1:0]   hpa, hpb, gs;
  logic [199:0] inj_map;
  logic [199:0] adv_q, adv_map, cur_map;
  logic [3:0]   p1x, p1y;
  logic [199:0] adv1_q, cur1_map;
  logic [3:0]   zero4;
  logic [1:0]   full_hp;
  int           n_checks;
  int           n_errors;

  bomb_placer_if hs ();
  bomb_placer_if hs1 ();

  // ---------------- clock / reset ----------------
  initial bombClk = 1'b0;
  always #5 bombClk = ~bombClk;

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  // ---------------- DUTs ----------------
  assign adv_map = adv_q | inj_map;

  bomb_placer #(.MAX_BOMBS(2), .COOLDOWN(1)) u_dut (
    .bombClk     (bombClk),
    .rst         (rst),
    .i_advMap    (adv_map),
    .playerAx    (pax),
    .playerAy    (pay),
    .playerBx    (pbx),
    .playerBy    (pby),
    .healthA     (hpa),
    .healthB     (hpb),
    .game_state  (gs),
    .o_curBombMap(cur_map),
    .hs          (hs)
  );

  // Budget-limited instance: one bomb, no cooldown.
  bomb_placer #(.MAX_BOMBS(1), .COOLDOWN(0)) u_dut1 (
    .bombClk     (bombClk),
    .rst         (rst),
    .i_advMap    (adv1_q),
    .playerAx    (p1x),
    .playerAy    (p1y),
    .playerBx    (zero4),
    .playerBy    (zero4),
    .healthA     (full_hp),
    .healthB     (full_hp),
    .game_state  (gs),
    .o_curBombMap(cur1_map),
    .hs          (hs1)
  );

  // ---------------- bomb-advance model: 1->2->3->0 per tick ----------------
  function automatic logic [199:0] advance(input logic [199:0] m);
    logic [199:0] r;
    logic [1:0]   c;
    for (int k = 0; k < 100; k++) begin
      c = m[2*k +: 2];
      r[2*k +: 2] = ((c == 2'd0) || (c == 2'd3)) ? 2'd0 : c + 2'd1;
    end
    return r;
  endfunction

  always @(posedge bombClk or posedge rst) begin
    if (rst) begin
      adv_q  <= '0;
      adv1_q <= '0;
    end else begin
      adv_q  <= advance(cur_map);
      adv1_q <= advance(cur1_map);
    end
  end

  // ---------------- driver / checker helpers ----------------
  task automatic tick();
    @(posedge bombClk);
    #1;
  endtask

  function automatic logic [1:0] cell_of(input logic [199:0] m, input int k);
    return m[2*k +: 2];
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    n_checks = 0;
    n_errors = 0;
    rst      = 1'b1;
    pax = 4'd0; pay = 4'd0; pbx = 4'd0; pby = 4'd0;
    p1x = 4'd0; p1y = 4'd0; zero4 = 4'd0;
    hpa = 2'd3; hpb = 2'd3; full_hp = 2'd3; gs = 2'd0;
    hs.reqA = 1'b0; hs.reqB = 1'b0;
    hs1.reqA = 1'b0; hs1.reqB = 1'b0;
    inj_map = '0;
    inj_map[1:0]     = 2'd3;  // cell 0 (border)
    inj_map[199:198] = 2'd3;  // cell 99 (border)
    inj_map[23:22]   = 2'd3;  // cell 11 (playable)

    // reset state
    repeat (2) tick();
    chk("rst_ackA", hs.o_ackA, 0);
    chk("rst_ackB", hs.o_ackB, 0);
    chk("rst_okA", hs.o_okA, 0);
    chk("rst_leftA", hs.o_bombsLeftA, 2);
    chk("rst_leftB", hs.o_bombsLeftB, 2);
    chk("rst_border0", cell_of(cur_map, 0), 0);
    chk("rst_border99", cell_of(cur_map, 99), 0);
    chk("rst_cell11", cell_of(cur_map, 11), 3);
    inj_map = '0;
    rst = 1'b0;
    repeat (2) tick();

    // single placement at (3,4) and its life cycle
    pax = 4'd3; pay = 4'd4;
    chk("p1_left_pre", hs.o_bombsLeftA, 2);
    hs.reqA = 1'b1;
    tick();
    chk("p1_ack", hs.o_ackA, 1);
    chk("p1_ok", hs.o_okA, 1);
    chk("p1_cell_t0", cell_of(cur_map, 34), 1);
    chk("p1_left_t0", hs.o_bombsLeftA, 1);
    hs.reqA = 1'b0;
    tick();
    chk("p1_ack_drop", hs.o_ackA, 0);
    chk("p1_cell_t1", cell_of(cur_map, 34), 2);
    chk("p1_left_t1", hs.o_bombsLeftA, 1);
    tick();
    chk("p1_cell_t2", cell_of(cur_map, 34), 3);
    chk("p1_left_t2", hs.o_bombsLeftA, 1);
    tick();
    chk("p1_cell_t3", cell_of(cur_map, 34), 0);
    chk("p1_left_t3", hs.o_bombsLeftA, 2);

    // A and B on the same cell: A wins
    repeat (2) tick();
    pax = 4'd5; pay = 4'd5; pbx = 4'd5; pby = 4'd5;
    hs.reqA = 1'b1; hs.reqB = 1'b1;
    tick();
    chk("col_okA", hs.o_okA, 1);
    chk("col_okB", hs.o_okB, 0);
    chk("col_ackB", hs.o_ackB, 1);
    chk("col_cell", cell_of(cur_map, 55), 1);
    chk("col_leftB", hs.o_bombsLeftB, 2);
    hs.reqA = 1'b0; hs.reqB = 1'b0;
    tick();
    chk("col_cell_t1", cell_of(cur_map, 55), 2);
    tick();
    chk("col_cell_t2", cell_of(cur_map, 55), 3);

    // A and B on different cells: both accepted
    pax = 4'd6; pay = 4'd6; pbx = 4'd7; pby = 4'd7;
    hs.reqA = 1'b1; hs.reqB = 1'b1;
    tick();
    chk("dif_okA", hs.o_okA, 1);
    chk("dif_okB", hs.o_okB, 1);
    chk("dif_cellA", cell_of(cur_map, 66), 1);
    chk("dif_cellB", cell_of(cur_map, 77), 1);
    hs.reqA = 1'b0; hs.reqB = 1'b0;
    repeat (4) tick();

    // occupied target cell
    inj_map[45:44] = 2'd2;  // cell 22
    pbx = 4'd2; pby = 4'd2;
    hs.reqB = 1'b1;
    tick();
    chk("occ_okB", hs.o_okB, 0);
    chk("occ_ackB", hs.o_ackB, 1);
    chk("occ_leftB", hs.o_bombsLeftB, 2);
    hs.reqB = 1'b0;
    inj_map = '0;
    repeat (4) tick();

    // dead player
    hpa = 2'd0; pax = 4'd4; pay = 4'd4;
    hs.reqA = 1'b1;
    tick();
    chk("dead_okA", hs.o_okA, 0);
    chk("dead_ackA", hs.o_ackA, 1);
    chk("dead_cell", cell_of(cur_map, 44), 0);
    hs.reqA = 1'b0; hpa = 2'd3;
    tick();

    // game over
    gs = 2'd2; pbx = 4'd4; pby = 4'd5;
    hs.reqB = 1'b1;
    tick();
    chk("over_okB", hs.o_okB, 0);
    chk("over_cell", cell_of(cur_map, 45), 0);
    hs.reqB = 1'b0; gs = 2'd0;
    tick();

    // non-playable coordinates, then playable corner (8,8)
    pax = 4'd0; pay = 4'd5; pbx = 4'd4; pby = 4'd9;
    hs.reqA = 1'b1; hs.reqB = 1'b1;
    tick();
    chk("edge_okA", hs.o_okA, 0);
    chk("edge_okB", hs.o_okB, 0);
    hs.reqA = 1'b0; hs.reqB = 1'b0;
    tick();
    pax = 4'd8; pay = 4'd8;
    hs.reqA = 1'b1;
    tick();
    chk("corner_okA", hs.o_okA, 1);
    chk("corner_cell", cell_of(cur_map, 88), 1);
    hs.reqA = 1'b0;
    repeat (4) tick();

    // req held for 3 ticks: one bomb only; then cooldown and re-request
    pax = 4'd6; pay = 4'd2;
    hs.reqA = 1'b1;
    tick();
    chk("hold_ack1", hs.o_ackA, 1);
    chk("hold_ok1", hs.o_okA, 1);
    chk("hold_cell1", cell_of(cur_map, 62), 1);
    chk("hold_left1", hs.o_bombsLeftA, 1);
    tick();
    chk("hold_ack2", hs.o_ackA, 1);
    chk("hold_cell2", cell_of(cur_map, 62), 2);
    chk("hold_left2", hs.o_bombsLeftA, 1);
    tick();
    chk("hold_ack3", hs.o_ackA, 1);
    chk("hold_ok3", hs.o_okA, 1);
    chk("hold_cell3", cell_of(cur_map, 62), 3);
    chk("hold_left3", hs.o_bombsLeftA, 1);
    hs.reqA = 1'b0;
    tick();
    chk("hold_drop", hs.o_ackA, 0);
    chk("hold_cell4", cell_of(cur_map, 62), 0);
    chk("hold_left4", hs.o_bombsLeftA, 2);
    hs.reqA = 1'b1;
    tick();
    chk("cool_ign", hs.o_ackA, 0);
    tick();
    chk("re_ack", hs.o_ackA, 1);
    chk("re_ok", hs.o_okA, 1);
    chk("re_cell", cell_of(cur_map, 62), 1);

    // asynchronous reset mid-handshake with a pending overlay
    inj_map[181:180] = 2'd1;  // cell 90 (border)
    rst = 1'b1;
    #1;
    chk("arst_ack", hs.o_ackA, 0);
    chk("arst_ok", hs.o_okA, 0);
    chk("arst_cell", cell_of(cur_map, 62), 0);
    chk("arst_left", hs.o_bombsLeftA, 2);
    chk("arst_border", cell_of(cur_map, 90), 0);
    hs.reqA = 1'b0;
    tick();
    rst = 1'b0;
    inj_map = '0;
    tick();
    chk("arst_after", hs.o_ackA, 0);

    // budget on the single-bomb, no-cooldown instance
    p1x = 4'd1; p1y = 4'd1;
    hs1.reqA = 1'b1;
    tick();
    chk("b_ok0", hs1.o_okA, 1);
    chk("b_left0", hs1.o_bombsLeftA, 0);
    chk("b_cell11", cell_of(cur1_map, 11), 1);
    hs1.reqA = 1'b0;
    tick();
    chk("b_ack_drop", hs1.o_ackA, 0);
    p1y = 4'd3;
    hs1.reqA = 1'b1;
    tick();
    chk("b_full_ack", hs1.o_ackA, 1);
    chk("b_full_ok", hs1.o_okA, 0);
    chk("b_full_cell", cell_of(cur1_map, 13), 0);
    chk("b_full_left", hs1.o_bombsLeftA, 0);
    hs1.reqA = 1'b0;
    tick();
    chk("b_freed", hs1.o_bombsLeftA, 1);
    chk("b_cell11_end", cell_of(cur1_map, 11), 0);
    hs1.reqA = 1'b1;
    tick();
    chk("b_retry_ok", hs1.o_okA, 1);
    chk("b_retry_cell", cell_of(cur1_map, 13), 1);
    chk("b_retry_left", hs1.o_bombsLeftA, 0);
    hs1.reqA = 1'b0;
    repeat (2) tick();
    // evaluated on the tick the only slot frees: counts as free
    p1y = 4'd5;
    hs1.reqA = 1'b1;
    tick();
    chk("b_same_ok", hs1.o_okA, 1);
    chk("b_same_cell", cell_of(cur1_map, 15), 1);
    chk("b_same_left", hs1.o_bombsLeftA, 0);
    hs1.reqA = 1'b0;
    tick();

    // ---------------- report ----------------
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
